// File: rtl/mac_accumulator.sv
// Sums groups of LEN MAC results into one wide result with a holding register.
// Define MAC_ACC_SAT_EN for saturating accumulation instead of modulo wrap.
module mac_accumulator #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  input  logic                 out_ready
);

  localparam int CW = $clog2(LEN);
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t state;
  state_t state_nxt;

  logic [ACC_WIDTH-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf;

  logic                 last;
  logic                 accept;
  logic                 done;
  logic                 drain;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] sum_val;

  assign last   = (cnt == LAST);
  assign in_ready = !clear &&
    !(out_valid && !out_ready && last);
  assign accept = in_valid && in_ready;
  assign done   = accept && last;
  assign drain  = out_valid && out_ready;

  assign sum = {1'b0, acc} +
    {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
  assign carry = sum[ACC_WIDTH];

`ifdef MAC_ACC_SAT_EN
  // Once a group has overflowed it stays pinned at all-ones.
  assign sum_val = (ovf || carry) ?
    {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
  assign sum_val = sum[ACC_WIDTH-1:0];
`endif

  assign out_valid = (state == FULL);

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (done) state_nxt = FULL;
      FULL:  if (drain && !done) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= sum_val;
        cnt <= cnt + CW'(1);
        ovf <= ovf | carry;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else if (done) begin
      out_data <= sum_val;
      out_ovf  <= ovf | carry;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator.
// Second instance uses ACC_WIDTH=9 for the overflow case.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_ready;

  logic        in_valid2;
  logic [7:0]  in_data2;
  logic        in_ready2;
  logic        out_valid2;
  logic [8:0]  out_data2;
  logic        out_ovf2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mac_accumulator #(
    .IN_WIDTH(8), .ACC_WIDTH(16), .LEN(4)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ovf(out_ovf),
    .out_ready(out_ready)
  );

  mac_accumulator #(
    .IN_WIDTH(8), .ACC_WIDTH(9), .LEN(4)
  ) dut9 (
    .clk(clk), .reset(reset), .clear(1'b0),
    .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .out_valid(out_valid2),
    .out_data(out_data2), .out_ovf(out_ovf2),
    .out_ready(1'b1)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h",
        tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] ovf_exp;

  initial begin
`ifdef MAC_ACC_SAT_EN
    ovf_exp = 9'h1FF;
`else
    ovf_exp = 9'h1FC;
`endif
    reset = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    in_valid2 = 1'b0;
    in_data2 = '0;
    cyc();
    cyc();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ovf", 32'(out_ovf), 0);
    reset = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 1);

    // basic group
    in_valid = 1'b1;
    in_data = 8'h16; cyc();
    in_data = 8'h43; cyc();
    in_data = 8'h7A; cyc();
    chk("basic_pre", 32'(out_valid), 0);
    in_data = 8'hF0; cyc();
    in_valid = 1'b0;
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_data", 32'(out_data), 32'h1C3);
    chk("basic_ovf", 32'(out_ovf), 0);
    cyc();
    chk("basic_pulse", 32'(out_valid), 0);

    // back-to-back groups
    in_data = 8'h01;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      #1;
      chk("b2b_ready", 32'(in_ready), 1);
      cyc();
      if (i == 3 || i == 7) begin
        chk("b2b_valid", 32'(out_valid), 1);
        chk("b2b_data", 32'(out_data), 4);
      end
      if (i == 4)
        chk("b2b_gap", 32'(out_valid), 0);
    end
    in_valid = 1'b0;
    cyc();

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h10;
    for (int i = 0; i < 4; i++) cyc();
    chk("bp_valid1", 32'(out_valid), 1);
    chk("bp_data1", 32'(out_data), 32'h40);
    for (int i = 0; i < 3; i++) begin
      chk("bp_accept", 32'(in_ready), 1);
      cyc();
    end
    chk("bp_stall", 32'(in_ready), 0);
    cyc();
    chk("bp_hold_v", 32'(out_valid), 1);
    chk("bp_hold_d", 32'(out_data), 32'h40);
    chk("bp_stall2", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    chk("bp_nobubble", 32'(out_valid), 1);
    chk("bp_data2", 32'(out_data), 32'h40);
    cyc();
    chk("bp_drained", 32'(out_valid), 0);

    // overflow on the 9-bit instance
    in_valid2 = 1'b1;
    in_data2 = 8'hFF;
    for (int i = 0; i < 4; i++) cyc();
    in_valid2 = 1'b0;
    chk("ovf_valid", 32'(out_valid2), 1);
    chk("ovf_data", 32'(out_data2), 32'(ovf_exp));
    chk("ovf_flag", 32'(out_ovf2), 1);
    cyc();

    // clear
    in_valid = 1'b1;
    in_data = 8'h05;
    cyc();
    cyc();
    clear = 1'b1;
    #1;
    chk("clr_ready", 32'(in_ready), 0);
    cyc();
    clear = 1'b0;
    in_data = 8'h02;
    for (int i = 0; i < 3; i++) cyc();
    chk("clr_early", 32'(out_valid), 0);
    cyc();
    in_valid = 1'b0;
    chk("clr_valid", 32'(out_valid), 1);
    chk("clr_data", 32'(out_data), 8);
    cyc();

    // reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h07;
    for (int i = 0; i < 4; i++) cyc();
    in_data = 8'h03;
    cyc();
    cyc();
    in_valid = 1'b0;
    chk("mid_pend", 32'(out_valid), 1);
    chk("mid_pdata", 32'(out_data), 32'h1C);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_ovf", 32'(out_ovf), 0);
    cyc();
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h03;
    for (int i = 0; i < 3; i++) cyc();
    chk("post_early", 32'(out_valid), 0);
    cyc();
    in_valid = 1'b0;
    chk("post_valid", 32'(out_valid), 1);
    chk("post_data", 32'(out_data), 32'h0C);
    cyc();

    $display("[TB] %0d tests run, %0d failed",
      tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream stage of the `mac` unit. It consumes the stream of per-cycle MAC results and sums each group of `LEN` consecutive accepted samples into one wide dot-product result. Each result is presented on a registered valid/ready output port. An output holding register lets accumulation of the next group continue while the previous result waits to be drained.

## Interface
Parameters:
- `IN_WIDTH`, 8, width of incoming MAC results; matches `mac` `OUT_WIDTH`.
- `ACC_WIDTH`, 16, accumulator and result width; must be ≥ `IN_WIDTH`.
- `LEN`, 4, samples per result; must be ≥ 2.

Ports:
- `clk`, input, 1, rising-edge clock.
- `reset`, input, 1, asynchronous, active-low reset.
- `clear`, input, 1, synchronous flush of the in-progress group.
- `in_valid`, input, 1, `in_data` is valid.
- `in_data`, input, `IN_WIDTH`, unsigned MAC result.
- `in_ready`, output, 1, block can accept `in_data` this cycle.
- `out_valid`, output, 1, result register holds an unread result.
- `out_data`, output, `ACC_WIDTH`, completed group sum.
- `out_ovf`, output, 1, group exceeded `ACC_WIDTH` during accumulation.
- `out_ready`, input, 1, consumer takes the result this cycle.

## Operation
- Internal state: accumulator `acc` (`ACC_WIDTH`), sample counter `cnt` (0..`LEN`-1), sticky overflow bit `ovf`, and the output register (`out_data`, `out_ovf`, `out_valid`).
- Input handshake: a sample is accepted when `in_valid && in_ready`.
- Output handshake: a result is drained when `out_valid && out_ready`.
- Arithmetic:
  - Unsigned only.
  - `in_data` is zero-extended to `ACC_WIDTH + 1` bits before the add.
  - Carry out of bit `ACC_WIDTH` sets `ovf`.
  - The stored sum wraps modulo 2^`ACC_WIDTH`; see Configuration for the saturating alternative.
- Accepted sample with `cnt < LEN-1`: `acc += in_data`, `cnt++`.
- Accepted sample with `cnt == LEN-1` (completing sample):
  - `out_data <= acc + in_data`, `out_ovf <= ovf | carry`, `out_valid <= 1`.
  - `acc`, `cnt` and `ovf` reset to 0 in the same edge.
- Output state machine:
  - EMPTY (`out_valid=0`): a completing sample moves it to FULL.
  - FULL (`out_valid=1`): a drain without a completing sample returns it to EMPTY.
  - FULL, drain and completing sample in the same cycle: stays FULL and loads the new result. No bubble and no loss.
- `in_ready` = `!clear && !(out_valid && !out_ready && cnt == LEN-1)`.
  - Non-completing samples are always accepted while FULL.
  - A completing sample stalls only while the previous result is undrained.
  - `in_ready` depends combinationally on `out_ready` and `clear`.
- `clear`:
  - Zeroes `acc`, `cnt` and `ovf`.
  - `in_ready` is low during `clear`, so no sample is accepted in that cycle.
  - Does not touch the output register. A pending result stays valid and can be drained in the same cycle.
- Reset (`reset` low, any time, including mid-group or with a result pending):
  - Immediately forces `acc=0`, `cnt=0`, `ovf=0`, `out_valid=0`, `out_data=0`, `out_ovf=0`.
  - The partial group and any pending result are discarded.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_ovf=0`.
- `in_ready=1` whenever `reset` is high, `clear` is low and the output state is EMPTY.
- Latency: `out_valid` rises on the edge that accepts the completing sample, so `out_data` is visible the cycle after that handshake.
- Throughput: with `out_ready` held high, one result per `LEN` accepted samples, no stall cycles.
- `out_data` and `out_ovf` stay stable while `out_valid && !out_ready`.
- Reset assertion is asynchronous. Deassertion is expected synchronous to `clk` from upstream reset logic.

## Configuration
- `MAC_ACC_SAT_EN` defined:
  - On carry out, the accumulator and the result load all-ones (2^`ACC_WIDTH`-1).
  - The sum stays saturated for the rest of that group.
  - `out_ovf` still reports the event.
- `MAC_ACC_SAT_EN` undefined: modulo wrap, with `out_ovf` reporting the event.

## Test plan
- Basic group:
  - Stimulus: reset low for 2 cycles, then samples 0x16, 0x43, 0x7A, 0xF0 on consecutive cycles, `out_ready=1`.
  - Required: `out_valid` pulses one cycle with `out_data=0x01C3`, `out_ovf=0`.
- Back-to-back groups, no backpressure:
  - Stimulus: 8 consecutive samples of 0x01.
  - Required: two results of 0x0004, each one cycle after its 4th sample, `in_ready` always 1.
- Backpressure:
  - Stimulus: `out_ready=0`, 8 samples of 0x10.
  - Required: first result 0x0040 is held. Samples 5–7 are accepted. `in_ready` drops at sample 8 until `out_ready=1`. On that drain edge the second 0x0040 loads with no bubble.
- Overflow, `ACC_WIDTH=9`:
  - Stimulus: 4 samples of 0xFF.
  - Required without `MAC_ACC_SAT_EN`: `out_data=0x1FC`, `out_ovf=1`.
  - Required with `MAC_ACC_SAT_EN`: `out_data=0x1FF`, `out_ovf=1`.
- Clear:
  - Stimulus: 2 samples of 0x05, `clear` for one cycle with `in_valid=1`, then 4 samples of 0x02.
  - Required: `in_ready=0` during the `clear` cycle, result 0x0008.
- Reset mid-operation:
  - Stimulus: a result pending with `out_ready=0` and 2 samples into the next group, then `reset` low for 1 cycle.
  - Required: `out_valid`, `out_data` and `out_ovf` go to 0 asynchronously. The next 4 samples of 0x03 give 0x000C.
